// File: rtl/wtc_7seg_multi.sv
// Multi-digit 7-segment driver with hex decode and animated display modes.
// Optional leading-zero blanking is enabled by defining WTC_7SEG_LEADING_ZERO_BLANK_EN.
module wtc_7seg_multi #(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned CNT_WIDTH  = 24,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [2:0]              i_Mode,
    input  logic [4*NUM_DIGITS-1:0] i_Binary_Num,
    input  logic [CNT_WIDTH-1:0]    i_Period,
    output logic [7*NUM_DIGITS-1:0] o_Segments,
    output logic                    o_Tick
);

    localparam logic [2:0] MODE_STATIC = 3'd0;
    localparam logic [2:0] MODE_BLANK  = 3'd1;
    localparam logic [2:0] MODE_LAMP   = 3'd2;
    localparam logic [2:0] MODE_BLINK  = 3'd3;
    localparam logic [2:0] MODE_SEGTOG = 3'd4;
    localparam logic [2:0] MODE_CHASE  = 3'd5;

    localparam logic [7*NUM_DIGITS-1:0] SEG_DARK = {(7*NUM_DIGITS){ACTIVE_LOW}};

    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    phase_q;
    logic [6:0]              tick_cnt_q;
    logic [2:0]              chase_q;
    logic [2:0]              mode_q;
    logic [4*NUM_DIGITS-1:0] num_q;
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
    logic                    tick_q;

    logic [CNT_WIDTH-1:0] period_m1;
    logic                 tick_hit;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0: hex_decode = 7'h7E;
            4'h1: hex_decode = 7'h30;
            4'h2: hex_decode = 7'h6D;
            4'h3: hex_decode = 7'h79;
            4'h4: hex_decode = 7'h33;
            4'h5: hex_decode = 7'h5B;
            4'h6: hex_decode = 7'h5F;
            4'h7: hex_decode = 7'h70;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h7B;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h1F;
            4'hC: hex_decode = 7'h4E;
            4'hD: hex_decode = 7'h3D;
            4'hE: hex_decode = 7'h4F;
            default: hex_decode = 7'h47;
        endcase
    endfunction

    // A zero period behaves as one clock per tick.
    always_comb begin
        period_m1 = (i_Period == '0) ? '0 : i_Period - 1'b1;
        tick_hit  = (cnt_q >= period_m1);
    end

`ifdef WTC_7SEG_LEADING_ZERO_BLANK_EN
    // upper_zero[d]: nibbles d..NUM_DIGITS-1 are all zero.
    logic [NUM_DIGITS-1:0] upper_zero;
    always_comb begin
        logic run;
        run        = 1'b1;
        upper_zero = '0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            run           = run & (num_q[4*d +: 4] == 4'h0);
            upper_zero[d] = run;
        end
    end
`endif

    always_comb begin
        logic [6:0] dec;
        logic [6:0] lit;
        seg_d = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            dec = hex_decode(num_q[4*d +: 4]);
`ifdef WTC_7SEG_LEADING_ZERO_BLANK_EN
            if (d > 0 && upper_zero[d]) begin
                dec = 7'h00;
            end
`endif
            case (mode_q)
                MODE_STATIC: lit = dec;
                MODE_BLANK:  lit = 7'h00;
                MODE_LAMP:   lit = 7'h7F;
                MODE_BLINK:  lit = phase_q ? dec : 7'h00;
                MODE_SEGTOG: lit = dec & ~tick_cnt_q;
                MODE_CHASE:  lit = 7'h40 >> chase_q;
                default:     lit = 7'h00;
            endcase
            seg_d[7*d +: 7] = ACTIVE_LOW ? ~lit : lit;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt_q      <= '0;
            phase_q    <= 1'b1;
            tick_cnt_q <= '0;
            chase_q    <= '0;
            mode_q     <= MODE_STATIC;
            num_q      <= '0;
            seg_q      <= SEG_DARK;
            tick_q     <= 1'b0;
        end else begin
            num_q <= i_Binary_Num;
            seg_q <= seg_d;
            // A mode change restarts the animation and suppresses the tick.
            if (i_Mode != mode_q) begin
                mode_q     <= i_Mode;
                cnt_q      <= '0;
                phase_q    <= 1'b1;
                tick_cnt_q <= '0;
                chase_q    <= '0;
                tick_q     <= 1'b0;
            end else if (tick_hit) begin
                cnt_q      <= '0;
                tick_q     <= 1'b1;
                phase_q    <= ~phase_q;
                tick_cnt_q <= tick_cnt_q + 7'd1;
                chase_q    <= (chase_q == 3'd5) ? 3'd0 : chase_q + 3'd1;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
                tick_q <= 1'b0;
            end
        end
    end

    assign o_Segments = seg_q;
    assign o_Tick     = tick_q;

endmodule
